// File: rtl/seq_alu_if.sv
// Handshake bundle for seq_alu: valid/ready operand channel in, valid/ready result channel out.
// The master drives operands and consumes results; the slave is the ALU itself.
interface seq_alu_if #(
  parameter int WIDTH = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     operand1;
  logic [WIDTH-1:0]     operand2;
  logic [1:0]           op;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   result;
  logic                 err;

  modport master (
    output in_valid, operand1, operand2, op, out_ready,
    input  in_ready, out_valid, result, err
  );

  modport slave (
    input  in_valid, operand1, operand2, op, out_ready,
    output in_ready, out_valid, result, err
  );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle add/sub, shift-add multiply and restoring divide that
// each resolve one bit per clock, so no wide combinational multiplier/divider is built.
module seq_alu #(
  parameter int WIDTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  seq_alu_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic [WIDTH-1:0]     r_b;
  logic [WIDTH-1:0]     r_shift;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0]   r_result;
  logic                 r_err;
  logic                 r_in_ready;
  logic                 r_out_valid;

  logic [2*WIDTH-1:0]   w_ext1;
  logic [2*WIDTH-1:0]   w_ext2;
  logic [2*WIDTH-1:0]   w_mul_acc;
  logic [WIDTH:0]       w_rem_sh;
  logic [WIDTH-1:0]     w_rem_next;
  logic [WIDTH-1:0]     w_quo_next;
  logic                 w_last;

  assign w_ext1 = {{WIDTH{1'b0}}, bus.operand1};
  assign w_ext2 = {{WIDTH{1'b0}}, bus.operand2};

  // r_shift holds the multiplier (consumed LSB first) or the dividend/quotient (MSB first).
  always_comb begin
    w_mul_acc  = r_acc + (r_shift[0] ? r_mcand : '0);
    w_rem_sh   = {r_acc[WIDTH-1:0], r_shift[WIDTH-1]};
    w_rem_next = w_rem_sh[WIDTH-1:0];
    w_quo_next = {r_shift[WIDTH-2:0], 1'b0};
    if (w_rem_sh >= {1'b0, r_b}) begin
      w_rem_next = w_rem_sh[WIDTH-1:0] - r_b;
      w_quo_next = {r_shift[WIDTH-2:0], 1'b1};
    end
    w_last = (r_cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_err       <= 1'b0;
      r_cnt       <= '0;
      r_b         <= '0;
      r_shift     <= '0;
      r_acc       <= '0;
      r_mcand     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_in_ready <= 1'b0;
            r_cnt      <= '0;
            r_b        <= bus.operand2;
            r_acc      <= '0;
            r_mcand    <= w_ext1;
            case (bus.op)
              2'b00: begin
                r_result    <= w_ext1 + w_ext2;
                r_err       <= 1'b0;
                r_out_valid <= 1'b1;
                r_state     <= DONE;
              end
              2'b01: begin
                r_result    <= w_ext1 - w_ext2;
                r_err       <= 1'b0;
                r_out_valid <= 1'b1;
                r_state     <= DONE;
              end
              2'b10: begin
                r_shift <= bus.operand2;
                r_state <= MUL;
              end
              default: begin
                // Divide by zero resolves immediately: quotient all ones, remainder = dividend.
                if (bus.operand2 == '0) begin
                  r_result    <= {bus.operand1, {WIDTH{1'b1}}};
                  r_err       <= 1'b1;
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
                end else begin
                  r_shift <= bus.operand1;
                  r_state <= DIV;
                end
              end
            endcase
          end
        end
        MUL: begin
          r_acc   <= w_mul_acc;
          r_mcand <= r_mcand << 1;
          r_shift <= r_shift >> 1;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            r_result    <= w_mul_acc;
            r_err       <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DIV: begin
          r_acc   <= {{WIDTH{1'b0}}, w_rem_next};
          r_shift <= w_quo_next;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            r_result    <= {w_rem_next, w_quo_next};
            r_err       <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.err       = r_err;
endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu at WIDTH=4 (directed + exhaustive) and WIDTH=8 (directed + random).
// Drivers push expected results into queues; negedge monitors pop and compare on each handshake.
module tb_seq_alu;
  logic clk = 1'b0;
  logic rst4;
  logic rst8;

  typedef struct {
    logic [15:0] res;
    logic        err;
  } exp_t;

  exp_t sb4[$];
  exp_t sb8[$];
  int   nChecks = 0;
  int   nFails  = 0;
  bit   done8   = 1'b0;

  seq_alu_if #(.WIDTH(4)) bus4 ();
  seq_alu_if #(.WIDTH(8)) bus8 ();

  seq_alu #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst4), .bus(bus4));
  seq_alu #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst8), .bus(bus8));

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Independent reference: plain integer arithmetic, masked to 2*w bits.
  function automatic exp_t refModel(input int w, input logic [1:0] o, input int a, input int b);
    exp_t e;
    int   mask;
    mask  = (1 << (2 * w)) - 1;
    e.err = 1'b0;
    case (o)
      2'd0:    e.res = 16'((a + b) & mask);
      2'd1:    e.res = 16'((a - b) & mask);
      2'd2:    e.res = 16'((a * b) & mask);
      default: begin
        if (b == 0) begin
          e.res = 16'((a << w) | ((1 << w) - 1));
          e.err = 1'b1;
        end else begin
          e.res = 16'(((a % b) << w) | (a / b));
        end
      end
    endcase
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic applyStimulus(input logic [1:0] o, input logic [3:0] a, input logic [3:0] b,
                               input logic [7:0] expRes, input logic expErr);
    int waitCnt = 0;
    exp_t e;
    while (bus4.in_ready !== 1'b1 && waitCnt < 50) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    if (waitCnt >= 50) checkOutput("w4 in_ready timeout", 32'(bus4.in_ready), 32'd1);
    bus4.op       = o;
    bus4.operand1 = a;
    bus4.operand2 = b;
    bus4.in_valid = 1'b1;
    e.res = {8'h00, expRes};
    e.err = expErr;
    sb4.push_back(e);
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
  endtask

  task automatic applyStimulus8(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                                input logic [15:0] expRes, input logic expErr);
    int waitCnt = 0;
    exp_t e;
    while (bus8.in_ready !== 1'b1 && waitCnt < 60) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    if (waitCnt >= 60) checkOutput("w8 in_ready timeout", 32'(bus8.in_ready), 32'd1);
    bus8.op       = o;
    bus8.operand1 = a;
    bus8.operand2 = b;
    bus8.in_valid = 1'b1;
    e.res = expRes;
    e.err = expErr;
    sb8.push_back(e);
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
  endtask

  // Counts negedges from the accept until out_valid appears; checks in_ready stays low meanwhile.
  task automatic measureLatency(input string name, input int expCycles);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
      if (bus4.out_valid !== 1'b1) checkOutput({name, " busy in_ready"}, 32'(bus4.in_ready), 32'd0);
    end while (bus4.out_valid !== 1'b1 && n < 20);
    checkOutput({name, " latency"}, 32'(n), 32'(expCycles));
    @(posedge clk); #1;
  endtask

  // Monitors: one pop per handshake, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst4 === 1'b0 && bus4.out_valid === 1'b1 && bus4.out_ready === 1'b1) begin
      if (sb4.size() == 0) begin
        checkOutput("w4 unexpected output", 32'(sb4.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb4.pop_front();
        checkOutput("w4 result", {24'h0, bus4.result}, {16'h0, e.res});
        checkOutput("w4 err", 32'(bus4.err), 32'(e.err));
      end
    end
  end

  always @(negedge clk) begin
    if (rst8 === 1'b0 && bus8.out_valid === 1'b1 && bus8.out_ready === 1'b1) begin
      if (sb8.size() == 0) begin
        checkOutput("w8 unexpected output", 32'(sb8.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb8.pop_front();
        checkOutput("w8 result", {16'h0, bus8.result}, {16'h0, e.res});
        checkOutput("w8 err", 32'(bus8.err), 32'(e.err));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, nChecks=%0d", nChecks);
    $fatal(1, "[TB] watchdog expired");
  end

  // WIDTH=8 flow: directed corners, then random sample.
  initial begin
    rst8 = 1'b1;
    bus8.in_valid = 1'b0; bus8.out_ready = 1'b1;
    bus8.operand1 = '0; bus8.operand2 = '0; bus8.op = '0;
    repeat (2) @(posedge clk);
    #3 rst8 = 1'b0;
    @(posedge clk); #1;
    applyStimulus8(2'd2, 8'd255, 8'd255, 16'hFE01, 1'b0);
    applyStimulus8(2'd3, 8'd200, 8'd7,   16'h041C, 1'b0);
    applyStimulus8(2'd1, 8'd0,   8'd1,   16'hFFFF, 1'b0);
    applyStimulus8(2'd3, 8'hAB,  8'd0,   16'hABFF, 1'b1);
    applyStimulus8(2'd0, 8'd255, 8'd1,   16'h0100, 1'b0);
    for (int i = 0; i < 2000; i++) begin
      logic [1:0] o;
      logic [7:0] a, b;
      exp_t e;
      o = 2'($urandom_range(0, 3));
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      e = refModel(8, o, int'(a), int'(b));
      applyStimulus8(o, a, b, e.res, e.err);
    end
    for (int i = 0; i < 40 && sb8.size() != 0; i++) @(posedge clk);
    #1 checkOutput("w8 scoreboard drained", 32'(sb8.size()), 32'd0);
    done8 = 1'b1;
  end

  // WIDTH=4 flow: reset, directed vectors, backpressure, reset mid-mul, exhaustive sweep.
  initial begin
    rst4 = 1'b1;
    bus4.in_valid = 1'b0; bus4.out_ready = 1'b1;
    bus4.operand1 = '0; bus4.operand2 = '0; bus4.op = '0;
    #2;
    checkOutput("reset in_ready",  32'(bus4.in_ready),  32'd1);
    checkOutput("reset out_valid", 32'(bus4.out_valid), 32'd0);
    checkOutput("reset result",    32'(bus4.result),    32'd0);
    checkOutput("reset err",       32'(bus4.err),       32'd0);
    repeat (2) @(posedge clk);
    #3 rst4 = 1'b0;
    @(posedge clk); #1;

    applyStimulus(2'd0, 4'd15, 4'd15, 8'h1E, 1'b0);
    measureLatency("add 15+15", 1);
    applyStimulus(2'd1, 4'd3, 4'd5, 8'hFE, 1'b0);
    applyStimulus(2'd1, 4'd5, 4'd3, 8'h02, 1'b0);
    applyStimulus(2'd2, 4'd15, 4'd15, 8'hE1, 1'b0);
    measureLatency("mul 15*15", 5);
    applyStimulus(2'd2, 4'd0, 4'd9, 8'h00, 1'b0);
    applyStimulus(2'd3, 4'd13, 4'd4, 8'h13, 1'b0);
    applyStimulus(2'd3, 4'd7, 4'd0, 8'h7F, 1'b1);
    measureLatency("div 7/0", 1);

    // Backpressure: result must hold while operands wiggle underneath.
    bus4.out_ready = 1'b0;
    applyStimulus(2'd2, 4'd15, 4'd15, 8'hE1, 1'b0);
    for (int i = 0; i < 20 && bus4.out_valid !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 6; i++) begin
      bus4.operand1 = 4'($urandom_range(0, 15));
      bus4.operand2 = 4'($urandom_range(0, 15));
      bus4.op       = 2'($urandom_range(0, 3));
      @(negedge clk);
      checkOutput("stall out_valid", 32'(bus4.out_valid), 32'd1);
      checkOutput("stall result",    32'(bus4.result),    32'hE1);
      checkOutput("stall in_ready",  32'(bus4.in_ready),  32'd0);
      @(posedge clk); #1;
    end
    bus4.out_ready = 1'b1;
    @(posedge clk); #1;

    // Leave err=1 in the output registers so the async reset has something to clear.
    applyStimulus(2'd3, 4'd7, 4'd0, 8'h7F, 1'b1);
    @(posedge clk); #1;
    applyStimulus(2'd2, 4'd9, 4'd7, 8'h3F, 1'b0);
    @(posedge clk); #1;
    rst4 = 1'b1;
    sb4.delete();
    #1;
    checkOutput("midrst out_valid", 32'(bus4.out_valid), 32'd0);
    checkOutput("midrst result",    32'(bus4.result),    32'd0);
    checkOutput("midrst err",       32'(bus4.err),       32'd0);
    checkOutput("midrst in_ready",  32'(bus4.in_ready),  32'd1);
    #1 rst4 = 1'b0;
    @(posedge clk); #1;
    applyStimulus(2'd0, 4'd1, 4'd1, 8'h02, 1'b0);

    for (int o = 0; o < 4; o++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          exp_t e;
          e = refModel(4, 2'(o), a, b);
          applyStimulus(2'(o), 4'(a), 4'(b), e.res[7:0], e.err);
        end
      end
    end
    for (int i = 0; i < 40 && sb4.size() != 0; i++) @(posedge clk);
    #1 checkOutput("w4 scoreboard drained", 32'(sb4.size()), 32'd0);

    for (int i = 0; i < 40000 && !done8; i++) @(posedge clk);
    checkOutput("w8 flow finished", 32'(done8), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
